// File: rtl/rot_block_iter.sv
// Iterative CORDIC rotation: replays the vectoring chain's micro-rotation directions
// on a second vector, one shift-add stage per cycle. Output keeps the CORDIC gain.
module rot_block_iter #(
  parameter int CORDIC_WIDTH    = 22,
  parameter int MICRO_ROT_STAGE = 15
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CORDIC_WIDTH-1:0] x_in,
  input  logic [CORDIC_WIDTH-1:0] y_in,
  input  logic [MICRO_ROT_STAGE:0] micro_rot_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CORDIC_WIDTH-1:0] x_out,
  output logic [CORDIC_WIDTH-1:0] y_out,
  output logic                    busy
);
  localparam int N     = MICRO_ROT_STAGE + 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MICRO_ROT_STAGE);

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]               cnt;
  logic [MICRO_ROT_STAGE:0]       rot;
  logic signed [CORDIC_WIDTH-1:0] x_w, y_w, x_sh, y_sh, x_nxt, y_nxt;
  logic                           last, accept;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == LAST);
  assign x_sh   = x_w >>> cnt;
  assign y_sh   = y_w >>> cnt;

  // direction bit 1 = counter-clockwise; both updates use the pre-update pair
  always_comb begin
    x_nxt = x_w + y_sh;
    y_nxt = y_w - x_sh;
    if (rot[cnt]) begin
      x_nxt = x_w - y_sh;
      y_nxt = y_w + x_sh;
    end
  end

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ROTATE;
      ROTATE:  if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      x_w   <= '0;
      y_w   <= '0;
      rot   <= '0;
      cnt   <= '0;
      x_out <= '0;
      y_out <= '0;
    end else if (accept) begin
      x_w <= x_in;
      y_w <= y_in;
      rot <= micro_rot_in;
      cnt <= '0;
    end else if (state == ROTATE) begin
      x_w <= x_nxt;
      y_w <= y_nxt;
      if (last) begin
        x_out <= x_nxt;
        y_out <= y_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == ROTATE) || (state == DONE);
endmodule

// File: tb/tb_rot_block_iter.sv
// Bench for rot_block_iter: default-size instance checked every cycle against a
// transaction-level model, plus 2-stage and 1-stage instances with literal vectors.
module tb_rot_block_iter;
  localparam int W = 22;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  x_in, y_in, x_out, y_out;
  logic [15:0]   rot_in;

  logic          v1, r1, ov1, b1;
  logic [W-1:0]  x1, y1, xo1, yo1;
  logic [1:0]    rot1;

  logic          v0, r0, ov0, b0;
  logic [W-1:0]  x0, y0, xo0, yo0;
  logic [0:0]    rot0;

  rot_block_iter u_dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .micro_rot_in(rot_in), .out_valid(out_valid),
    .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .busy(busy));

  rot_block_iter #(.CORDIC_WIDTH(W), .MICRO_ROT_STAGE(1)) u_s1 (
    .clk(clk), .nreset(nreset), .in_valid(v1), .in_ready(r1),
    .x_in(x1), .y_in(y1), .micro_rot_in(rot1), .out_valid(ov1),
    .out_ready(1'b1), .x_out(xo1), .y_out(yo1), .busy(b1));

  rot_block_iter #(.CORDIC_WIDTH(W), .MICRO_ROT_STAGE(0)) u_s0 (
    .clk(clk), .nreset(nreset), .in_valid(v0), .in_ready(r0),
    .x_in(x0), .y_in(y0), .micro_rot_in(rot0), .out_valid(ov0),
    .out_ready(1'b1), .x_out(xo0), .y_out(yo0), .busy(b0));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint wrapw(input longint v);
    longint m = longint'(1) << W;
    longint r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // floor(v / 2^s) with plain integer division
  function automatic longint fshift(input longint v, input int s);
    longint p = longint'(1) << s;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  task automatic model(input longint xi, input longint yi, input logic [31:0] b,
                       input int n, output longint xr, output longint yr);
    longint x = wrapw(xi);
    longint y = wrapw(yi);
    longint xs, ys;
    for (int i = 0; i < n; i++) begin
      xs = fshift(x, i);
      ys = fshift(y, i);
      if (b[i]) begin xr = x - ys; yr = y + xs; end
      else      begin xr = x + ys; yr = y - xs; end
      x = wrapw(xr);
      y = wrapw(yr);
    end
    xr = x;
    yr = y;
  endtask

  // transaction-level expectation for the default instance
  bit     busy_e = 0, vld_e = 0;
  int     left = 0;
  longint xo_e = 0, yo_e = 0, xr_p, yr_p;
  always @(posedge clk or negedge nreset)
    if (!nreset) begin
      busy_e = 0; vld_e = 0; left = 0; xo_e = 0; yo_e = 0;
    end else if (!busy_e) begin
      if (in_valid) begin
        busy_e = 1;
        left   = 16;
        model(sx(x_in), sx(y_in), {16'b0, rot_in}, 16, xr_p, yr_p);
      end
    end else if (left > 0) begin
      left--;
      if (left == 0) begin vld_e = 1; xo_e = xr_p; yo_e = yr_p; end
    end else if (out_ready) begin
      vld_e = 0; busy_e = 0;
    end

  int rises = 0;
  bit ov_q  = 0;
  always @(negedge clk) begin
    chk("out_valid", longint'(out_valid), longint'(vld_e));
    chk("busy", longint'(busy), longint'(busy_e));
    chk("in_ready", longint'(in_ready), longint'(!busy_e));
    chk("x_out", sx(x_out), xo_e);
    chk("y_out", sx(y_out), yo_e);
    if (out_valid && !ov_q) rises++;
    ov_q = out_valid;
  end

  task automatic run1(input string nm, input longint xi, input longint yi,
                      input logic [1:0] b, input longint ex, input longint ey);
    int k = 0;
    @(negedge clk);
    x1 = W'(xi); y1 = W'(yi); rot1 = b; v1 = 1;
    @(negedge clk);
    v1 = 0;
    while (!ov1 && k < 10) begin @(negedge clk); k++; end
    chk({nm, " lat"}, k, 2);
    chk({nm, " x"}, sx(xo1), ex);
    chk({nm, " y"}, sx(yo1), ey);
  endtask

  task automatic send(input longint xi, input longint yi, input logic [15:0] b);
    x_in = W'(xi); y_in = W'(yi); rot_in = b; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  // waits for out_valid; optionally pulses a stray in_valid while busy
  task automatic wait_ov(input int pulse_at, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == pulse_at) begin x_in = W'(77); in_valid = 1; end
      else in_valid = 0;
    end
    in_valid = 0;
  endtask

  longint xr, yr;
  int     lat, k, base;
  longint vx[3] = '{2097151, -2000000, 0};
  longint vy[3] = '{-2097152, -2000000, 1};
  logic [15:0] vb[3] = '{16'h0000, 16'hFFFF, 16'h1234};

  initial begin
    nreset = 0; in_valid = 0; out_ready = 1; x_in = '0; y_in = '0; rot_in = '0;
    v1 = 0; x1 = '0; y1 = '0; rot1 = '0;
    v0 = 0; x0 = '0; y0 = '0; rot0 = '0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", longint'(in_ready), 1);
    chk("rst out_valid", longint'(out_valid), 0);
    chk("rst x_out", sx(x_out), 0);
    #2 nreset = 1;

    model(1000, 0, 32'b10, 2, xr, yr);
    chk("model cw/ccw x", xr, 1500);
    chk("model cw/ccw y", yr, -500);
    model(2000000, 2000000, 32'b0, 1, xr, yr);
    chk("model wrap x", xr, -194304);
    chk("model wrap y", yr, 0);

    run1("s1 00", 1000, 0, 2'b00, 500, -1500);
    run1("s1 11", 1000, 0, 2'b11, 500, 1500);
    run1("s1 10", 1000, 0, 2'b10, 1500, -500);
    run1("s1 floor", 0, -3, 2'b00, -5, -1);

    @(negedge clk);
    x0 = W'(2000000); y0 = W'(2000000); rot0 = 1'b0; v0 = 1;
    @(negedge clk);
    v0 = 0;
    k = 0;
    while (!ov0 && k < 10) begin @(negedge clk); k++; end
    chk("s0 wrap lat", k, 1);
    chk("s0 wrap x", sx(xo0), -194304);
    chk("s0 wrap y", sx(yo0), 0);

    // default size: latency with a stray in_valid during ROTATE
    @(negedge clk);
    send(300000, -150000, 16'hA5C3);
    wait_ov(5, lat);
    chk("latency", lat, 16);
    @(negedge clk);

    // backpressure, stray in_valid in DONE, then back-to-back vector
    out_ready = 0;
    send(-1500000, 900000, 16'h5A3C);
    wait_ov(0, lat);
    chk("bp latency", lat, 16);
    model(-1500000, 900000, 32'h5A3C, 16, xr, yr);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      @(negedge clk);
      chk("bp out_valid", longint'(out_valid), 1);
      chk("bp in_ready", longint'(in_ready), 0);
      chk("bp x hold", sx(x_out), xr);
      chk("bp y hold", sx(y_out), yr);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    chk("bp release out_valid", longint'(out_valid), 0);
    chk("bp release in_ready", longint'(in_ready), 1);
    send(123456, -654321, 16'hFFFF);
    wait_ov(0, lat);
    chk("b2b latency", lat, 16);
    model(123456, -654321, 32'hFFFF, 16, xr, yr);
    chk("b2b x", sx(x_out), xr);
    chk("b2b y", sx(y_out), yr);
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      send(vx[i], vy[i], vb[i]);
      wait_ov(0, lat);
      chk("vec latency", lat, 16);
      @(negedge clk);
    end
    chk("result count", rises, 6);

    // reset during ROTATE discards the operation
    base = rises;
    send(500000, 400000, 16'h0F0F);
    repeat (5) @(negedge clk);
    #2 nreset = 0;
    #1;
    chk("mid rst out_valid", longint'(out_valid), 0);
    chk("mid rst busy", longint'(busy), 0);
    chk("mid rst in_ready", longint'(in_ready), 1);
    chk("mid rst x_out", sx(x_out), 0);
    chk("mid rst y_out", sx(y_out), 0);
    @(negedge clk);
    #2 nreset = 1;
    repeat (25) @(negedge clk);
    chk("no result after reset", rises, base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rot_block_iter.md
# rot_block_iter

Iterative CORDIC rotation engine that consumes the micro-rotation direction bits produced by the vectoring chain (stages 0..MICRO_ROT_STAGE, last stage included) and applies the same rotation sequence to a second vector. It sits downstream of the vectoring block in the Givens/ICA datapath. It is a one-micro-rotation-per-cycle shift-add engine with a valid/ready handshake on both sides. Output carries the uncompensated CORDIC gain (~1.64676); scale compensation happens downstream.

## Interface
- CORDIC_WIDTH, 22, two's-complement width of all x/y data
- MICRO_ROT_STAGE, 15, index of last micro-rotation; N = MICRO_ROT_STAGE+1 micro-rotations per vector
- clk  in  1  clock, rising edge
- nreset  in  1  reset, asynchronous, active-low
- in_valid  in  1  input vector and direction bits valid
- in_ready  out  1  block idle and able to accept; high only in IDLE
- x_in, y_in  in  CORDIC_WIDTH each  signed vector to rotate
- micro_rot_in  in  MICRO_ROT_STAGE+1  bit i = direction of stage i (0 clockwise, 1 counter-clockwise), same encoding as the vectoring stages' micro_rot_o
- out_valid  out  1  x_out/y_out hold a completed result
- out_ready  in  1  downstream accepts result
- x_out, y_out  out  CORDIC_WIDTH each  signed rotated vector (registered)
- busy  out  1  high in ROTATE or DONE

## Operation
- States: IDLE, ROTATE, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: capture x_in, y_in, micro_rot_in into working regs, stage counter i=0, go ROTATE. Inputs ignored in all other states.
- ROTATE: each cycle apply stage i using captured bit d=micro_rot[i]:
  - d=0: x' = x + (y>>>i), y' = y - (x>>>i)
  - d=1: x' = x - (y>>>i), y' = y + (x>>>i)
  - both updates use pre-update x,y; >>> arithmetic (sign-extending, floor truncation); add/sub modulo 2^CORDIC_WIDTH, no saturation, no guard bits.
  - i increments; after stage i=MICRO_ROT_STAGE, load x_out/y_out with result, go DONE.
- DONE: out_valid=1, x_out/y_out stable. On out_ready: out_valid drops, go IDLE. out_valid held indefinitely while out_ready=0.
- x_out/y_out keep the last result after leaving DONE until the next completion overwrites them.
- Counter width ceil(log2(N)); counter never exceeds MICRO_ROT_STAGE.

## Timing
- Reset (async, immediate): state IDLE, in_ready=1, out_valid=0, busy=0, x_out=y_out=0, working regs and counter 0.
- Accept edge E0 -> stages 0..MICRO_ROT_STAGE on edges E1..EN -> out_valid=1 after edge EN (latency N cycles; 16 with defaults).
- Result transfer at edge with out_valid&&out_ready; in_ready=1 in the following cycle. Minimum initiation interval N+2 cycles (accept, N rotates, transfer, re-accept next cycle from IDLE).
- in_ready and busy are decoded from the state register (no combinational path from in_valid/out_ready).
- nreset asserted mid-ROTATE or in DONE: operation discarded, no out_valid produced, outputs to reset values.

## Test plan
- Reset: drive nreset low mid-ROTATE -> immediately out_valid=0, busy=0, in_ready=1, x_out=y_out=0; no result emitted after release.
- MICRO_ROT_STAGE=1, x_in=1000, y_in=0: micro_rot_in=2'b00 -> (500,-1500); 2'b11 -> (500,1500); 2'b10 (stage0 cw, stage1 ccw) -> (1500,-500).
- Floor shift, MICRO_ROT_STAGE=1, x_in=0, y_in=-3, bits 2'b00 -> (-5,-1).
- Wrap, MICRO_ROT_STAGE=0, x_in=2000000, y_in=2000000, bit 0 -> x_out=-194304, y_out=0.
- Defaults, any vector: out_valid rises exactly 16 cycles after accept edge; in_valid pulses during ROTATE/DONE ignored (no second result).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, x_out, y_out stable, in_ready=0; out_ready=1 -> out_valid falls next edge, in_ready=1 next cycle; back-to-back second vector produces correct result.
